// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchroniser, tick prescaler, qualification FSM
// and a saturating counter of rejected transitions for bring-up diagnostics.
module button_debouncer #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned STABLE_SAMPLES = 10,
    parameter logic        IDLE_LEVEL     = 1'b0,
    parameter int unsigned GLITCH_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_raw,
    input  logic                glitch_clr,
    output logic                btn_clean,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_DONE   = CNT_W'(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0]    CNT_FIRST  = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        ST_STABLE0  = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_STABLE1  = 2'd2,
        ST_FALL_CHK = 2'd3
    } state_e;

    localparam state_e RESET_STATE = IDLE_LEVEL ? ST_STABLE1 : ST_STABLE0;

    logic                s1_q;
    logic                s2_q;
    logic [PRE_W-1:0]    pre_q;
    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                clean_q;
    logic                busy_q;
    logic [GLITCH_W-1:0] glitch_q;

    logic                tick_c;
    logic [CNT_W-1:0]    cnt_inc_c;
    logic                reject_c;

    // Metastability guard: only s2_q is observed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= IDLE_LEVEL;
            s2_q <= IDLE_LEVEL;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Free-running sample-tick prescaler, never restarted by input activity.
    assign tick_c = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (tick_c) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // A candidate level that reverts before qualifying is a rejected transition.
    assign reject_c = tick_c &&
                      (((state_q == ST_RISE_CHK) && !s2_q) ||
                       ((state_q == ST_FALL_CHK) &&  s2_q));

    // Qualification FSM; busy and btn_clean are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            clean_q <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else if (tick_c) begin
            unique case (state_q)
                ST_STABLE0: begin
                    if (s2_q) begin
                        state_q <= ST_RISE_CHK;
                        cnt_q   <= CNT_FIRST;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RISE_CHK: begin
                    if (!s2_q) begin
                        state_q <= ST_STABLE0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_inc_c == CNT_DONE) begin
                        state_q <= ST_STABLE1;
                        cnt_q   <= '0;
                        clean_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_inc_c;
                    end
                end
                ST_STABLE1: begin
                    if (!s2_q) begin
                        state_q <= ST_FALL_CHK;
                        cnt_q   <= CNT_FIRST;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FALL_CHK: begin
                    if (s2_q) begin
                        state_q <= ST_STABLE1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_inc_c == CNT_DONE) begin
                        state_q <= ST_STABLE0;
                        cnt_q   <= '0;
                        clean_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_inc_c;
                    end
                end
                default: begin
                    state_q <= RESET_STATE;
                    cnt_q   <= '0;
                    clean_q <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating diagnostic counter; a same-cycle clear overrides an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if (glitch_clr) begin
            glitch_q <= '0;
        end else if (reject_c && (glitch_q != GLITCH_MAX)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign btn_clean  = clean_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;

    localparam int unsigned DIV  = 4;
    localparam int unsigned SS   = 3;
    localparam int unsigned GW   = 4;
    localparam int unsigned GMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_raw = 1'b0;
    logic          glitch_clr = 1'b0;
    logic          btn_clean;
    logic          busy;
    logic [GW-1:0] glitch_cnt;

    logic          btn_raw1 = 1'b0;
    logic          glitch_clr1 = 1'b0;
    logic          btn_clean1;
    logic          busy1;
    logic [GW-1:0] glitch_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .CLK_DIV(DIV), .STABLE_SAMPLES(SS), .IDLE_LEVEL(1'b0), .GLITCH_W(GW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .glitch_clr(glitch_clr),
        .btn_clean(btn_clean), .busy(busy), .glitch_cnt(glitch_cnt)
    );

    button_debouncer #(
        .CLK_DIV(1), .STABLE_SAMPLES(SS), .IDLE_LEVEL(1'b0), .GLITCH_W(GW)
    ) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw1), .glitch_clr(glitch_clr1),
        .btn_clean(btn_clean1), .busy(busy1), .glitch_cnt(glitch_cnt1)
    );

    // Reference: raw delayed two cycles, sampled every DIV-th edge; a run of SS
    // samples differing from the accepted level flips it, a shorter run is a glitch.
    typedef struct packed {
        bit          d1;
        bit          d2;
        int unsigned cyc;
        bit          clean;
        int unsigned run;
        int unsigned glitch;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, bit raw, bit clr);
        model_t nxt;
        bit     inc;
        nxt = cur;
        inc = 1'b0;
        if ((cur.cyc % DIV) == DIV - 1) begin
            if (cur.d2 != cur.clean) begin
                nxt.run = cur.run + 1;
                if (nxt.run == SS) begin
                    nxt.clean = ~cur.clean;
                    nxt.run   = 0;
                end
            end else if (cur.run != 0) begin
                inc     = 1'b1;
                nxt.run = 0;
            end
        end
        if (clr) nxt.glitch = 0;
        else if (inc && cur.glitch < GMAX) nxt.glitch = cur.glitch + 1;
        nxt.d2  = cur.d1;
        nxt.d1  = raw;
        nxt.cyc = cur.cyc + 1;
        return nxt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, btn_raw, glitch_clr);
    end

    task automatic test_reset;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn_raw = ~btn_raw;
        end
        btn_raw = 1'b0;
        @(negedge clk);
        n_checks++;
        if (btn_clean !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 4'd0)
            $display("FAIL reset_held clean=%b busy=%b glitch=%0d want 0/0/0", btn_clean, busy, glitch_cnt);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (btn_clean !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 4'd0)
            $display("FAIL reset_release clean=%b busy=%b glitch=%0d want 0/0/0", btn_clean, busy, glitch_cnt);
    endtask

    task automatic test_clean_edge(input bit level, input int unsigned exp_glitch);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        btn_raw = level;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            n_checks++;
            if (btn_clean !== m.clean || busy !== (m.run != 0)) begin
                n_fail++;
                $display("FAIL edge%0b_model cyc=%0d clean=%b busy=%b want %b/%b",
                         level, i, btn_clean, busy, m.clean, (m.run != 0));
            end
            if (btn_clean === level) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        n_checks++;
        if (!seen || lat < 11 || lat > 14) begin
            n_fail++;
            $display("FAIL edge%0b_latency got=%0d seen=%b want 11..14", level, lat, seen);
        end
        n_checks++;
        if (busy !== 1'b0 || glitch_cnt !== GW'(exp_glitch)) begin
            n_fail++;
            $display("FAIL edge%0b_after busy=%b glitch=%0d want 0/%0d", level, busy, glitch_cnt, exp_glitch);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_bounce_press;
        int  lat;
        bit  seen;
        btn_raw = 1'b1;
        repeat (8) @(negedge clk);
        btn_raw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (btn_clean !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_early clean=%b want 0", btn_clean);
            end
        end
        btn_raw = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (btn_clean === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        n_checks++;
        if (!seen || lat < 11 || lat > 14) begin
            n_fail++;
            $display("FAIL bounce_latency got=%0d seen=%b want 11..14", lat, seen);
        end
        n_checks++;
        if (glitch_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL bounce_glitch got=%0d want 1", glitch_cnt);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_subtick_glitch(input int unsigned exp_glitch);
        int guard;
        guard = 0;
        while (((m.cyc + 2) % DIV) == DIV - 1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        btn_raw = 1'b1;
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || btn_clean !== 1'b0 || glitch_cnt !== GW'(exp_glitch)) begin
                n_fail++;
                $display("FAIL subtick busy=%b clean=%b glitch=%0d want 0/0/%0d",
                         busy, btn_clean, glitch_cnt, exp_glitch);
            end
        end
    endtask

    task automatic test_saturation;
        bit hit;
        for (int k = 0; k < 20; k++) begin
            btn_raw = 1'b1;
            repeat (4) @(negedge clk);
            btn_raw = 1'b0;
            repeat (8) @(negedge clk);
        end
        n_checks++;
        if (glitch_cnt !== 4'd15 || btn_clean !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_count glitch=%0d clean=%b want 15/0", glitch_cnt, btn_clean);
        end
        btn_raw = 1'b1;
        repeat (4) @(negedge clk);
        btn_raw = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m.run != 0 && m.d2 == 1'b0 && (m.cyc % DIV) == DIV - 1) begin
                glitch_clr = 1'b1;
                hit = 1'b1;
            end
            @(negedge clk);
        end
        glitch_clr = 1'b0;
        n_checks++;
        if (!hit || glitch_cnt !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_vs_reject hit=%b glitch=%0d busy=%b want 1/0/0", hit, glitch_cnt, busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random;
        int unsigned hold;
        for (int seg = 0; seg < 60; seg++) begin
            btn_raw = 1'($urandom_range(0, 1));
            hold    = $urandom_range(1, 20);
            for (int c = 0; c < int'(hold); c++) begin
                glitch_clr = ($urandom_range(0, 49) == 0);
                @(negedge clk);
                n_checks++;
                if (btn_clean !== m.clean || busy !== (m.run != 0) || glitch_cnt !== GW'(m.glitch)) begin
                    n_fail++;
                    $display("FAIL random t=%0t clean=%b busy=%b glitch=%0d want %b/%b/%0d", $time,
                             btn_clean, busy, glitch_cnt, m.clean, (m.run != 0), m.glitch);
                end
            end
        end
        glitch_clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        int guard;
        btn_raw = ~m.clean;
        guard = 0;
        while (m.run == 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy got=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (btn_clean !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_async clean=%b busy=%b glitch=%0d want 0/0/0", btn_clean, busy, glitch_cnt);
        end
        btn_raw = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (btn_clean !== 1'b0 || busy !== 1'b0 || glitch_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_after clean=%b busy=%b glitch=%0d want 0/0/0", btn_clean, busy, glitch_cnt);
        end
    endtask

    task automatic test_clkdiv1;
        @(negedge clk);
        btn_raw1 = 1'b1;
        repeat (2) @(negedge clk);
        btn_raw1 = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (glitch_cnt1 !== 4'd1 || btn_clean1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL div1 glitch=%0d clean=%b busy=%b want 1/0/0", glitch_cnt1, btn_clean1, busy1);
        end
    endtask

    initial begin
        test_reset;
        test_clean_edge(1'b1, 0);
        test_clean_edge(1'b0, 0);
        test_bounce_press;
        test_clean_edge(1'b0, 1);
        test_subtick_glitch(1);
        test_saturation;
        test_random;
        test_reset_mid;
        test_clkdiv1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
